dram_tx_streamer: RTL and testbench

DRAM_TX_STREAMER -- requirements
Module: dram_tx_streamer

---
 rtl/dram_tx_streamer.sv | 135 +++++++++++++
 tb/tb_dram_tx_streamer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_tx_streamer.sv
// dram_tx_streamer: streams a RAM frame byte-wise to a UART transmitter.
// Define DRAM_TX_CHECKSUM_EN to append a modulo-256 checksum byte.
module dram_tx_streamer #(
  parameter int NUM_BYTES = 16384,
  parameter int RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_n,
  output logic [15:0] ram_addr,
  input  logic [7:0]  ram_data,
  output logic [7:0]  tx_byte,
  output logic        tx_dv,
  input  logic        tx_done,
  input  logic        tx_active,
  output logic        busy,
  output logic        fin
);

  localparam logic [15:0] LAST_ADDR = 16'(NUM_BYTES - 1);
  localparam logic [1:0]  WAIT_INIT = 2'(RD_LAT - 1);

`ifdef DRAM_TX_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, RD_WAIT, SEND, TX_WAIT, NEXT, DONE, CSUM
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD_WAIT, SEND, TX_WAIT, NEXT, DONE
  } state_t;
`endif

  state_t     state;
  logic [1:0] wait_cnt;
`ifdef DRAM_TX_CHECKSUM_EN
  logic [7:0] csum;
  logic       csum_phase;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ram_addr <= '0;
      tx_byte  <= '0;
      tx_dv    <= 1'b0;
      busy     <= 1'b0;
      fin      <= 1'b0;
      wait_cnt <= '0;
`ifdef DRAM_TX_CHECKSUM_EN
      csum       <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      tx_dv <= 1'b0;
      unique case (state)
        IDLE: begin
          ram_addr <= '0;
          if (!start_n) begin
            state    <= RD_WAIT;
            busy     <= 1'b1;
            wait_cnt <= WAIT_INIT;
`ifdef DRAM_TX_CHECKSUM_EN
            csum       <= '0;
            csum_phase <= 1'b0;
`endif
          end
        end
        RD_WAIT: begin
          if (wait_cnt == 2'd0) begin
            tx_byte <= ram_data;
`ifdef DRAM_TX_CHECKSUM_EN
            csum    <= csum + ram_data;
`endif
            state   <= SEND;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        SEND: begin
          if (!tx_active) begin
            tx_dv <= 1'b1;
            state <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          if (tx_done) begin
`ifdef DRAM_TX_CHECKSUM_EN
            if (csum_phase) begin
              state <= DONE;
              busy  <= 1'b0;
              fin   <= 1'b1;
            end else begin
              state <= NEXT;
            end
`else
            state <= NEXT;
`endif
          end
        end
        NEXT: begin
          if (ram_addr == LAST_ADDR) begin
`ifdef DRAM_TX_CHECKSUM_EN
            state <= CSUM;
`else
            state <= DONE;
            busy  <= 1'b0;
            fin   <= 1'b1;
`endif
          end else begin
            ram_addr <= ram_addr + 16'd1;
            wait_cnt <= WAIT_INIT;
            state    <= RD_WAIT;
          end
        end
`ifdef DRAM_TX_CHECKSUM_EN
        CSUM: begin
          tx_byte    <= csum;
          csum_phase <= 1'b1;
          state      <= SEND;
        end
`endif
        DONE: begin
          // a start_n still held low must not start another frame
          if (start_n) begin
            state    <= IDLE;
            fin      <= 1'b0;
            ram_addr <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_tx_streamer.sv
// tb_dram_tx_streamer: directed tests plus a per-cycle frame model
// checking four streamer configurations side by side.
module tb_dram_tx_streamer;

  localparam int NI = 4;
`ifdef DRAM_TX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  function automatic int nb(input int i);
    case (i)
      0: return 4;
      1: return 4;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int rl(input int i);
    case (i)
      0: return 1;
      1: return 3;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NI-1:0] start_n;
  logic [NI-1:0] tx_active;
  logic [NI-1:0] spur_done;
  logic [7:0] mem [NI][4];

  wire [15:0] ram_addr [NI];
  wire [7:0]  ram_data [NI];
  wire [7:0]  tx_byte  [NI];
  wire [NI-1:0] tx_dv;
  wire [NI-1:0] busy;
  wire [NI-1:0] fin;

  int checks = 0;
  int failures = 0;
  int idx [NI];
  int frames [NI];
  bit pdv [NI];
  bit pact [NI];
  bit pfin [NI];
  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : inst
    localparam int RL = rl(g);
    logic [7:0] pipe [3];
    logic rdone;
    int   rcnt;
    wire  tdone;

    assign tdone = rdone | spur_done[g];

    always @(posedge clk) begin
      pipe[0] <= mem[g][ram_addr[g][1:0]];
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end

    if (RL == 1) begin : comb_rd
      assign ram_data[g] = mem[g][ram_addr[g][1:0]];
    end else begin : pipe_rd
      assign ram_data[g] = pipe[RL-2];
    end

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rcnt  <= 0;
        rdone <= 1'b0;
      end else begin
        rdone <= 1'b0;
        if (tx_dv[g]) begin
          rcnt <= 10;
        end else if (rcnt > 0) begin
          rcnt <= rcnt - 1;
          if (rcnt == 1) rdone <= 1'b1;
        end
      end
    end

    dram_tx_streamer #(
      .NUM_BYTES(nb(g)),
      .RD_LAT   (RL)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_n  (start_n[g]),
      .ram_addr (ram_addr[g]),
      .ram_data (ram_data[g]),
      .tx_byte  (tx_byte[g]),
      .tx_dv    (tx_dv[g]),
      .tx_done  (tdone),
      .tx_active(tx_active[g]),
      .busy     (busy[g]),
      .fin      (fin[g])
    );
  end

  function automatic int flen(input int i);
    return nb(i) + CS;
  endfunction

  // frame bytes in order, then the mod-256 sum of the frame
  function automatic logic [7:0] expb(input int i, input int k);
    logic [7:0] s;
    if (k < nb(i)) return mem[i][k];
    s = 8'h00;
    for (int j = 0; j < nb(i); j++) s = s + mem[i][j];
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp,
               $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!rst_n) begin
          chk($sformatf("rst_addr%0d", i), ram_addr[i], 0);
          chk($sformatf("rst_byte%0d", i), tx_byte[i], 0);
          chk($sformatf("rst_dv%0d", i), tx_dv[i], 0);
          chk($sformatf("rst_busy%0d", i), busy[i], 0);
          chk($sformatf("rst_fin%0d", i), fin[i], 0);
          idx[i]  = 0;
          pdv[i]  = 1'b0;
          pfin[i] = 1'b0;
          pact[i] = tx_active[i];
        end else begin
          chk($sformatf("addr_rng%0d", i),
              ram_addr[i] <= 16'(nb(i) - 1), 1);
          chk($sformatf("busy_fin%0d", i), busy[i] & fin[i], 0);
          if (tx_dv[i]) begin
            chk($sformatf("dv_pulse%0d", i), pdv[i], 0);
            chk($sformatf("dv_active%0d", i), pact[i], 0);
            chk($sformatf("dv_extra%0d", i), idx[i] < flen(i), 1);
            chk($sformatf("byte%0d_%0d", i, idx[i]), tx_byte[i],
                expb(i, idx[i]));
            idx[i]++;
          end
          if (fin[i] && !pfin[i]) begin
            chk($sformatf("frame_len%0d", i), idx[i], flen(i));
            idx[i] = 0;
            frames[i]++;
          end
          pdv[i]  = tx_dv[i];
          pact[i] = tx_active[i];
          pfin[i] = fin[i];
        end
      end
    end
  endtask

  task automatic run_frame(input int i, input int budget);
    bit ok;
    ok = 1'b0;
    got_q.delete();
    for (int c = 0; c < budget; c++) begin
      tick(1);
      if (tx_dv[i]) got_q.push_back(tx_byte[i]);
      if (fin[i]) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("fin_timeout%0d", i), ok, 1);
  endtask

  task automatic wait_dvs(input int i, input int n, input int budget);
    int seen;
    seen = 0;
    for (int c = 0; c < budget && seen < n; c++) begin
      tick(1);
      if (tx_dv[i]) seen++;
    end
    chk($sformatf("dv_timeout%0d", i), seen, n);
  endtask

  task automatic cmp_frame(input string nm);
    chk({nm, "_len"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk($sformatf("%s_b%0d", nm, k), got_q[k], exp_q[k]);
  endtask

  initial begin
    int first;
    int f0;
    int cnt;
    start_n   = '1;
    tx_active = '0;
    spur_done = '0;
    mem[0] = '{8'h11, 8'h22, 8'h33, 8'h44};
    mem[1] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    mem[2] = '{8'hFF, 8'h02, 8'h00, 8'h00};
    mem[3] = '{8'h5A, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < NI; i++) begin
      idx[i] = 0;
      frames[i] = 0;
    end
    fork
      monitor();
    join_none

    tick(3);
    chk("rst_state_busy", busy[0], 0);
    chk("rst_state_addr", ram_addr[0], 0);
    chk("rst_state_byte", tx_byte[0], 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_busy", busy[0], 0);
    chk("idle_fin", fin[0], 0);

    // basic 4-byte frame, start_n released mid-frame
    start_n[0] = 1'b0;
    tick(1);
    chk("t1_busy", busy[0], 1);
    start_n[0] = 1'b1;
    run_frame(0, 300);
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
`ifdef DRAM_TX_CHECKSUM_EN
    exp_q.push_back(8'hAA);
`endif
    cmp_frame("t1");
    chk("t1_fin", fin[0], 1);
    chk("t1_busy_done", busy[0], 0);
    tick(2);
    chk("t1_idle_fin", fin[0], 0);
    chk("t1_idle_addr", ram_addr[0], 0);

    // RD_LAT=3 start latency, spurious tx_done in RD_WAIT
    start_n[1] = 1'b0;
    tick(1);
    chk("t2_busy", busy[1], 1);
    spur_done[1] = 1'b1;
    first = 99;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      spur_done[1] = 1'b0;
      chk("t2_addr0", ram_addr[1], 0);
      if (tx_dv[1]) begin
        first = k;
        break;
      end
    end
    start_n[1] = 1'b1;
    chk("t2_first_dv", first, 4);
    chk("t2_first_byte", tx_byte[1], 8'hA1);
    run_frame(1, 300);
    exp_q = {8'hB2, 8'hC3, 8'hD4};
`ifdef DRAM_TX_CHECKSUM_EN
    exp_q.push_back(8'hEA);
`endif
    cmp_frame("t2");
    tick(2);

    // tx_active holds SEND for 20 cycles
    tx_active[0] = 1'b1;
    start_n[0]   = 1'b0;
    tick(2);
    start_n[0] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      spur_done[0] = (c == 5);
      tick(1);
      cnt += int'(tx_dv[0]);
    end
    spur_done[0] = 1'b0;
    chk("t3_held_dv", cnt, 0);
    tx_active[0] = 1'b0;
    tick(1);
    chk("t3_dv_after", tx_dv[0], 1);
    chk("t3_byte", tx_byte[0], 8'h11);
    run_frame(0, 300);
    exp_q = {8'h22, 8'h33, 8'h44};
`ifdef DRAM_TX_CHECKSUM_EN
    exp_q.push_back(8'hAA);
`endif
    cmp_frame("t3");
    tick(2);

    // asynchronous reset after the second byte
    start_n[0] = 1'b0;
    tick(1);
    start_n[0] = 1'b1;
    wait_dvs(0, 2, 100);
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_async_busy", busy[0], 0);
    chk("t4_async_addr", ram_addr[0], 0);
    chk("t4_async_byte", tx_byte[0], 0);
    chk("t4_async_dv", tx_dv[0], 0);
    tick(2);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      cnt += int'(tx_dv[0]);
    end
    chk("t4_no_dv", cnt, 0);
    chk("t4_idle_busy", busy[0], 0);
    start_n[0] = 1'b0;
    tick(1);
    start_n[0] = 1'b1;
    run_frame(0, 300);
    exp_q = {8'h11, 8'h22, 8'h33, 8'h44};
`ifdef DRAM_TX_CHECKSUM_EN
    exp_q.push_back(8'hAA);
`endif
    cmp_frame("t4");
    tick(2);

    // start_n held low through DONE
    f0 = frames[0];
    start_n[0] = 1'b0;
    run_frame(0, 300);
    cmp_frame("t5a");
    tick(30);
    chk("t5_fin_hold", fin[0], 1);
    chk("t5_busy_hold", busy[0], 0);
    chk("t5_addr_hold", ram_addr[0], 3);
    chk("t5_one_frame", frames[0], f0 + 1);
    start_n[0] = 1'b1;
    tick(2);
    chk("t5_idle_fin", fin[0], 0);
    chk("t5_idle_addr", ram_addr[0], 0);
    start_n[0] = 1'b0;
    run_frame(0, 300);
    cmp_frame("t5b");
    start_n[0] = 1'b1;
    tick(2);
    chk("t5_two_frames", frames[0], f0 + 2);

    // two-byte frame, checksum byte when enabled
    start_n[2] = 1'b0;
    tick(1);
    start_n[2] = 1'b1;
    run_frame(2, 300);
    exp_q = {8'hFF, 8'h02};
`ifdef DRAM_TX_CHECKSUM_EN
    exp_q.push_back(8'h01);
`endif
    cmp_frame("t6");
    chk("t6_fin", fin[2], 1);
    tick(2);

    // single-byte frame
    start_n[3] = 1'b0;
    tick(1);
    start_n[3] = 1'b1;
    run_frame(3, 200);
    exp_q = {8'h5A};
`ifdef DRAM_TX_CHECKSUM_EN
    exp_q.push_back(8'h5A);
`endif
    cmp_frame("t7");
    chk("t7_addr", ram_addr[3], 0);
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
